// File: rtl/bridge_pkg.sv
// Shared widths, state encoding and the default DM/T0/T1 address map for the system bridge.
package bridge_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Bridge FSM states.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;

  // Default map: slave 0 = DM, slave 1 = Timer0, slave 2 = Timer1.
  localparam int          DEF_N_SLV   = 3;
  localparam logic [95:0] DEF_BASE    = {32'h7f10, 32'h7f00, 32'h0000};
  localparam logic [95:0] DEF_LIMIT   = {32'h7f1b, 32'h7f0b, 32'h2fff};
  localparam logic [2:0]  DEF_BYTE_OK = 3'b001;
endpackage

// File: rtl/addr_decoder.sv
// Combinational window decoder: one-hot hit vector (lowest index wins) plus hit-valid.
module addr_decoder
  import bridge_pkg::*;
#(
  parameter int                      N_SLV = DEF_N_SLV,
  parameter logic [N_SLV*ADDR_W-1:0] BASE  = DEF_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] LIMIT = DEF_LIMIT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  hit,
  output logic              hit_vld
);
  logic [N_SLV-1:0] raw;

  // Inclusive range compare per window.
  for (genvar i = 0; i < N_SLV; i++) begin : g_win
    assign raw[i] = (addr >= BASE[i*ADDR_W +: ADDR_W]) && (addr <= LIMIT[i*ADDR_W +: ADDR_W]);
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign hit     = raw & (~raw + 1'b1);
  assign hit_vld = |raw;
endmodule

// File: rtl/sys_bridge_n.sv
// Handshaked CPU-to-slave bridge: registered decode, wait-state tolerant, bus error on
// unmapped / illegal partial write / timeout.
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int                      N_SLV   = DEF_N_SLV,
  parameter logic [N_SLV*ADDR_W-1:0] BASE    = DEF_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] LIMIT   = DEF_LIMIT,
  parameter logic [N_SLV-1:0]        BYTE_OK = DEF_BYTE_OK,
  parameter int                      TO_MAX  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_req,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  input  logic [BE_W-1:0]           m_byteen,
  output logic                      m_ready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
  output logic [N_SLV-1:0]          s_sel,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [BE_W-1:0]           s_byteen,
  input  logic [N_SLV*DATA_W-1:0]   s_rdata,
  input  logic [N_SLV-1:0]          s_ack
);
  localparam int CW = $clog2(TO_MAX + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [N_SLV-1:0] hit;
  logic             hit_vld;
  logic             bad_be;
  logic             ack;
  logic [DATA_W-1:0] sel_rdata;

  addr_decoder #(.N_SLV(N_SLV), .BASE(BASE), .LIMIT(LIMIT)) u_dec (
    .addr    (m_addr),
    .hit     (hit),
    .hit_vld (hit_vld)
  );

  // Partial write to a word-only slave is rejected before any slave sees it.
  assign bad_be = (|(hit & ~BYTE_OK)) && (m_byteen != '0) && (m_byteen != '1);
  // Only the selected slave's ack counts.
  assign ack    = |(s_ack & s_sel);

  // Read-data mux driven by the one-hot select.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++)
      if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
  end

  // FSM, payload registers, timeout counter and registered master response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      s_sel    <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_byteen <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          m_ready <= 1'b0;
          m_rdata <= '0;
          m_err   <= 1'b0;
          if (m_req) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            cnt     <= '0;
            if (!hit_vld || bad_be) begin
              state   <= S_RESP;
              m_ready <= 1'b1;
              m_err   <= 1'b1;
            end else begin
              state    <= S_WAIT;
              s_sel    <= hit;
              s_byteen <= m_byteen;
            end
          end
        end
        S_WAIT: begin
          if (ack) begin
            // Writes return zero data.
            m_rdata  <= (s_byteen == '0) ? sel_rdata : '0;
            m_err    <= 1'b0;
            m_ready  <= 1'b1;
            s_sel    <= '0;
            s_byteen <= '0;
            state    <= S_RESP;
          end else if (cnt == CW'(TO_MAX - 1)) begin
            m_rdata  <= '0;
            m_err    <= 1'b1;
            m_ready  <= 1'b1;
            s_sel    <= '0;
            s_byteen <= '0;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          m_ready <= 1'b0;
          m_rdata <= '0;
          m_err   <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          s_sel    <= '0;
          s_byteen <= '0;
          m_ready  <= 1'b0;
          m_rdata  <= '0;
          m_err    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sys_bridge_n.sv
// Table-driven bench with an expected-response queue for sys_bridge_n (default map, TO_MAX=15).
module tb_sys_bridge_n;
  logic        clk = 1'b0;
  logic        reset;
  logic        m_req;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_byteen;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [2:0]  s_sel;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_byteen;
  logic [95:0] s_rdata;
  logic [2:0]  s_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sys_bridge_n dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byteen(m_byteen), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_idx;   // -1: nobody acks
    int          ack_k;     // ack in WAIT cycle k (0-based)
    logic [2:0]  noise;     // acks from other slaves before ack_k
    logic [31:0] rd;        // slave i returns rd + i
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_selc;
    logic [2:0]  exp_sel;
  } vec_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          selc;
  } exp_t;

  vec_t tbl[12];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] a, logic [31:0] wd, logic [3:0] be, int ai, int ak,
                              logic [2:0] nz, logic [31:0] rd, logic [31:0] erd, logic ee,
                              int lat, int selc, logic [2:0] sel);
    vec_t v;
    v.addr = a; v.wdata = wd; v.be = be; v.ack_idx = ai; v.ack_k = ak; v.noise = nz;
    v.rd = rd; v.exp_rd = erd; v.exp_err = ee; v.exp_lat = lat; v.exp_selc = selc; v.exp_sel = sel;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int   cyc, selc;
    logic done, sel_ok;
    exp_t e, got;
    e.rd = v.exp_rd; e.err = v.exp_err; e.lat = v.exp_lat; e.selc = v.exp_selc;
    sb.push_back(e);
    s_rdata = {v.rd + 32'd2, v.rd + 32'd1, v.rd};
    @(negedge clk);
    m_req = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_byteen = v.be;
    cyc = 0; selc = 0; done = 1'b0; sel_ok = 1'b1;
    got = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      s_ack = 3'b000;
      if (m_ready) begin
        got.rd = m_rdata; got.err = m_err; got.lat = cyc; got.selc = selc;
        done = 1'b1;
        m_req = 1'b0;
      end else if (s_sel != 3'b000) begin
        selc++;
        if (s_sel !== v.exp_sel || s_byteen !== v.be || s_addr !== v.addr || s_wdata !== v.wdata)
          sel_ok = 1'b0;
        if (v.ack_idx >= 0 && selc - 1 == v.ack_k) s_ack[v.ack_idx] = 1'b1;
        else if (selc - 1 < v.ack_k) s_ack = v.noise;
      end
    end
    m_req = 1'b0;
    s_ack = 3'b000;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL vec%0d no m_ready within 40 cycles", idx);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk($sformatf("vec%0d latency", idx), got.lat, e.lat);
      chk($sformatf("vec%0d rdata", idx), got.rd, e.rd);
      chk($sformatf("vec%0d err", idx), 32'(got.err), 32'(e.err));
      chk($sformatf("vec%0d sel_cycles", idx), got.selc, e.selc);
      chk($sformatf("vec%0d sel_payload_ok", idx), 32'(sel_ok), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d ready_pulse_one_cycle", idx), {31'd0, m_ready}, 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " s_sel"}, 32'(s_sel), 32'd0);
    chk({tag, " s_byteen"}, 32'(s_byteen), 32'd0);
    chk({tag, " s_addr"}, s_addr, 32'd0);
    chk({tag, " s_wdata"}, s_wdata, 32'd0);
    chk({tag, " m_ready"}, 32'(m_ready), 32'd0);
    chk({tag, " m_rdata"}, m_rdata, 32'd0);
    chk({tag, " m_err"}, 32'(m_err), 32'd0);
  endtask

  initial begin
    //          addr        wdata        be     ai  ak  noise   rd            exp_rd        err  lat selc sel
    tbl[0]  = mk(32'h0100, 32'h0,        4'h0,  0,  0, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2,  1, 3'b001);
    tbl[1]  = mk(32'h7f04, 32'h12345678, 4'hF,  1,  3, 3'b000, 32'h55,       32'h0,        1'b0, 5,  4, 3'b010);
    tbl[2]  = mk(32'h7f10, 32'hCAFE,     4'h3, -1,  0, 3'b000, 32'h77,       32'h0,        1'b1, 1,  0, 3'b000);
    tbl[3]  = mk(32'h5000, 32'h0,        4'h0, -1,  0, 3'b000, 32'h99,       32'h0,        1'b1, 1,  0, 3'b000);
    tbl[4]  = mk(32'h7f14, 32'h0,        4'h0, -1,  0, 3'b000, 32'h1234,     32'h0,        1'b1, 16, 15, 3'b100);
    tbl[5]  = mk(32'h7f14, 32'h0,        4'h0,  2, 14, 3'b000, 32'hA5A50000, 32'hA5A50002, 1'b0, 16, 15, 3'b100);
    tbl[6]  = mk(32'h0200, 32'h0,        4'h0,  0,  2, 3'b010, 32'h11112222, 32'h11112222, 1'b0, 4,  3, 3'b001);
    tbl[7]  = mk(32'h2fff, 32'hBEEF,     4'h3,  0,  1, 3'b000, 32'h44,       32'h0,        1'b0, 3,  2, 3'b001);
    tbl[8]  = mk(32'h7f1b, 32'h0,        4'h0,  2,  0, 3'b000, 32'h100,      32'h102,      1'b0, 2,  1, 3'b100);
    tbl[9]  = mk(32'h7f0c, 32'h0,        4'h0, -1,  0, 3'b000, 32'h5,        32'h0,        1'b1, 1,  0, 3'b000);
    tbl[10] = mk(32'h3000, 32'h0,        4'h0, -1,  0, 3'b000, 32'h6,        32'h0,        1'b1, 1,  0, 3'b000);
    tbl[11] = mk(32'h7f00, 32'h0,        4'h1, -1,  0, 3'b000, 32'h7,        32'h0,        1'b1, 1,  0, 3'b000);

    reset = 1'b0; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_byteen = '0;
    s_rdata = '0; s_ack = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run(tbl[i], i);

    // Reset in the middle of a WAIT: everything clears and no completion follows.
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h0300; m_wdata = 32'h0; m_byteen = 4'h0;
    repeat (3) @(negedge clk);
    chk("mid sel before reset", 32'(s_sel), 32'd1);
    reset = 1'b0; m_req = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no pulse after abort %0d", i), 32'(m_ready), 32'd0);
    end

    run(tbl[0], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
